// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR flip-flop sequencer: FSM state encoding and op codes.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2,
      ACK    = 2'd3
   } state_e;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   input  logic            gnt_en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o
);

   int            k;
   logic [IW-1:0] kk;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      k     = 0;
      kk    = '0;
      if (gnt_en_i) begin
         for (int i = 0; i < NREQ; i++) begin
            // Rotate the search origin to the pointer, wrapping without a modulo.
            k = int'(ptr_i) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = IW'(k);
            if (!found && req_i[kk]) begin
               found     = 1'b1;
               gnt_o[kk] = 1'b1;
               idx_o     = kk;
            end
         end
      end
   end

endmodule

// File: rtl/sr_ff_sequencer.sv
// Arbitrates set/clear requests onto one gated SR flip-flop, pulsing S or R with
// enable, waiting a settle time, then verifying the stored value via q_fb.
module sr_ff_sequencer
   import sr_ctrl_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] op,
   input  logic            q_fb,
   output logic            s,
   output logic            r,
   output logic            en,
   output logic [NREQ-1:0] ack,
   output logic            err,
   output logic            busy
);

   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   idx_q, ptr_q, ptr_d, gnt_idx;
   logic [NREQ-1:0] gnt, ack_q;
   logic            op_q, chk_q, s_q, r_q, en_q, busy_q;
   logic            gnt_en;

   assign gnt_en = (state_q == IDLE);

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .gnt_en_i (gnt_en),
      .gnt_o    (gnt),
      .idx_o    (gnt_idx)
   );

   // The winner drops to lowest priority for the next arbitration.
   always_comb begin
      ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         op_q    <= OP_CLR;
         chk_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         en_q    <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  idx_q   <= gnt_idx;
                  op_q    <= op[gnt_idx];
                  s_q     <= (op[gnt_idx] == OP_SET);
                  r_q     <= (op[gnt_idx] == OP_CLR);
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  ptr_q   <= ptr_d;
                  cnt_q   <= PULSE_LD;
                  state_q <= PULSE;
               end
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
                  en_q    <= 1'b0;
                  cnt_q   <= SETTLE_LD;
                  state_q <= SETTLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  chk_q   <= q_fb;
                  ack_q   <= NREQ'(1) << idx_q;
                  state_q <= ACK;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ACK: begin
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s    = s_q;
   assign r    = r_q;
   assign en   = en_q;
   assign ack  = ack_q;
   assign busy = busy_q;
   // err depends only on registers, so q_fb has no combinational path out.
   assign err  = (state_q == ACK) && (chk_q != op_q);

endmodule

// File: tb/tb_sr_ff_sequencer.sv
// Scoreboard bench: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_sr_ff_sequencer;

   localparam int NREQ = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req, op, ack;
   logic            q_fb, s, r, en, err, busy;
   logic [NREQ-1:0] req_b, op_b, ack_b;
   logic            s_b, r_b, en_b, err_b, busy_b;
   logic            ff_q = 1'b0;
   logic            force_q0;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      int   idx;
      logic err;
      int   cyc;
   } exp_t;
   exp_t sbq[$];
   exp_t e;

   sr_ff_sequencer #(.NREQ(NREQ), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .q_fb(q_fb),
      .s(s), .r(r), .en(en), .ack(ack), .err(err), .busy(busy)
   );

   sr_ff_sequencer #(.NREQ(NREQ), .PULSE_CYCLES(1), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .op(op_b), .q_fb(1'b1),
      .s(s_b), .r(r_b), .en(en_b), .ack(ack_b), .err(err_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural gated SR flip-flop driven by the DUT.
   always @(posedge clk) begin
      if (en && s)      ff_q <= 1'b1;
      else if (en && r) ff_q <= 1'b0;
   end
   assign q_fb = force_q0 ? 1'b0 : ff_q;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int idx, input logic er, input int c);
      exp_t x;
      x.idx = idx; x.err = er; x.cyc = c;
      sbq.push_back(x);
   endtask

   // Each requester drops its req on the ack cycle unless listed in hold.
   task automatic service(input logic [NREQ-1:0] hold, input int n, input int budget);
      int got = 0;
      int t   = 0;
      while (got < n && t < budget) begin
         @(negedge clk); #1; t++;
         for (int i = 0; i < NREQ; i++)
            if (ack[i]) begin
               got++;
               if (!hold[i]) req[i] = 1'b0;
            end
      end
      chk("service_ack_count", got, n);
      req = '0;
      @(posedge clk); #1;
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("inv_s_and_r", int'(s & r), 0);
         chk("inv_drive_without_en", int'((s | r) & ~en), 0);
         chk("inv_b_s_and_r", int'(s_b & r_b), 0);
         if (ack != '0 || err) begin
            if (sbq.size() == 0) begin
               chk("unexpected_ack_err", int'({ack, err}), 0);
            end else begin
               e = sbq.pop_front();
               chk("ack_onehot", int'(ack), 1 << e.idx);
               chk("ack_err", int'(err), int'(e.err));
               chk("ack_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, en_len, ack_at;
      logic err_seen;
      rst = 1'b1; req = '0; op = '0; force_q0 = 1'b0; req_b = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s", int'(s), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_en", int'(en), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;

      // Single set then single clear from requester 0
      req = 4'b0001; op = 4'b0001; c0 = cyc; push(0, 1'b0, c0 + 4);
      @(negedge clk); @(negedge clk);
      chk("set_s_c1", int'(s), 1); chk("set_en_c1", int'(en), 1);
      chk("set_r_c1", int'(r), 0); chk("set_busy_c1", int'(busy), 1);
      @(negedge clk);
      chk("set_s_c2", int'(s), 1);
      @(negedge clk);
      chk("set_en_c3", int'(en), 0); chk("set_s_c3", int'(s), 0);
      service('0, 1, 20);
      chk("q_after_set", int'(ff_q), 1);
      chk("idle_busy", int'(busy), 0);
      req = 4'b0001; op = 4'b0000; c0 = cyc; push(0, 1'b0, c0 + 4);
      @(negedge clk); @(negedge clk);
      chk("clr_r_c1", int'(r), 1); chk("clr_s_c1", int'(s), 0); chk("clr_en_c1", int'(en), 1);
      service('0, 1, 20);
      chk("q_after_clr", int'(ff_q), 0);

      // All four at once, asserted during reset: serviced 0,1,2,3
      rst = 1'b1; req = 4'b1111; op = 4'b1010;
      reset_cycles(2);
      c0 = cyc;
      push(0, 1'b0, c0 + 4); push(1, 1'b0, c0 + 9);
      push(2, 1'b0, c0 + 14); push(3, 1'b0, c0 + 19);
      service('0, 4, 60);
      chk("q_after_four", int'(ff_q), 1);

      // Fairness: 0 and 2 held high alternate
      req = '0; reset_cycles(2);
      req = 4'b0101; op = 4'b0101; c0 = cyc;
      push(0, 1'b0, c0 + 4); push(2, 1'b0, c0 + 9);
      push(0, 1'b0, c0 + 14); push(2, 1'b0, c0 + 19);
      service(4'b0101, 4, 60);

      // Stuck-at-0 Q: set from requester 1 reports err with ack
      reset_cycles(2);
      force_q0 = 1'b1;
      req = 4'b0010; op = 4'b0010; c0 = cyc; push(1, 1'b1, c0 + 4);
      service('0, 1, 20);
      force_q0 = 1'b0;

      // Reset during PULSE abandons the op and clears the pointer
      reset_cycles(2);
      req = 4'b0100; op = 4'b0100; c0 = cyc;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1; req = '0;
      @(posedge clk); #1;
      chk("abort_s", int'(s), 0); chk("abort_r", int'(r), 0);
      chk("abort_en", int'(en), 0); chk("abort_busy", int'(busy), 0);
      chk("abort_ack", int'(ack), 0); chk("abort_err", int'(err), 0);
      rst = 1'b0;
      req = 4'b1010; op = 4'b0000; c0 = cyc;
      push(1, 1'b0, c0 + 4); push(3, 1'b0, c0 + 9);
      service('0, 2, 40);
      chk("q_after_abort_clr", int'(ff_q), 0);

      // Short pulse, long settle instance
      req_b = 4'b0001; op_b = 4'b0001; c0 = cyc;
      en_len = 0; ack_at = -1; err_seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (en_b) en_len++;
         if (ack_b[0] && ack_at < 0) begin
            ack_at = cyc; err_seen = err_b; req_b = '0;
         end
      end
      chk("b_en_len", en_len, 1);
      chk("b_ack_cycle", ack_at, c0 + 5);
      chk("b_err", int'(err_seen), 0);

      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/sr_ff_sequencer.md
# sr_ff_sequencer

Sequencer and round-robin arbiter in front of one shared gated SR flip-flop (NAND-based, enable on its clock input). It accepts set/clear requests from NREQ requesters and drives the flip-flop's S, R and enable inputs. It guarantees S=R=1 is never applied, holds each pulse for a programmed width, waits a settle time, then checks the stored value through Q feedback. The block sits between the control logic that owns a status flag and the gate-level storage element.

## Interface
- NREQ, 4: number of requesters (2..8)
- PULSE_CYCLES, 2: cycles S or R and enable are held (>=1)
- SETTLE_CYCLES, 1: idle cycles after a pulse before Q is checked (>=1)

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request; held high until its ack
- op  input  NREQ  per-requester operation: 1 = set, 0 = clear; stable while req high
- q_fb  input  1  Q output of the SR flip-flop
- s  output  1  S drive to flip-flop
- r  output  1  R drive to flip-flop
- en  output  1  enable (clock/gate) drive to flip-flop
- ack  output  NREQ  one-hot, one-cycle completion pulse
- err  output  1  one-cycle pulse with ack when q_fb != requested value
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, PULSE, SETTLE, ACK.
- IDLE: if any req is high, the round-robin arbiter picks winner idx. The block latches idx and op[idx] and goes to PULSE. Otherwise it stays in IDLE.
- PULSE: en=1. s=op_l and r=~op_l. Stays PULSE_CYCLES cycles, then goes to SETTLE.
- SETTLE: s=r=en=0 for SETTLE_CYCLES cycles. In the last SETTLE cycle the block samples q_fb into chk, then goes to ACK.
- ACK: ack[idx]=1 and err=(chk != op_l) for exactly one cycle, then back to IDLE.
- Invariant: s&r is never 1. s|r implies en.
- Round-robin: the priority pointer is 0 after reset. After servicing idx, the pointer becomes (idx+1) mod NREQ, so that requester has the lowest priority next.
- Only one operation is in flight. Requests arriving while busy wait, with no loss, as long as req stays high.
- Conflicting simultaneous set and clear from different requesters are serialized by arbitration. The later-serviced operation determines the final Q.
- The block never reads req or op outside IDLE. Changes to op mid-operation are ignored because op_l is latched.
- Pulse and settle share one counter of width $clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1). The counter reloads on each state entry.

## Timing
- Reset values: s=0, r=0, en=0, ack=0, err=0, busy=0. State is IDLE, pointer is 0, counter is 0.
- All outputs are driven from registers; there is no combinational path from req or q_fb to any output.
- Latency: if req is high in IDLE cycle 0, PULSE runs cycles 1..P, SETTLE runs cycles P+1..P+S, and ack is high in cycle P+S+1. With defaults (P=2, S=1), ack arrives in cycle 4. The next operation can start at IDLE cycle P+S+2 at the earliest.
- Handshake: the requester drops req on the edge ending its ack cycle. IDLE ignores a req that is still high from the just-acked requester only if that requester has dropped it by the IDLE sampling edge. A requester that keeps req high is re-serviced per round-robin.
- Reset mid-operation: on the rst edge, s, r and en go to 0 and state goes to IDLE. The in-flight operation is abandoned with no ack and no err. The pointer goes to 0.
- rst asserted together with req: reset wins; the first arbitration happens in the first cycle after rst falls.

## Structure
- Package sr_ctrl_pkg holds:
  - the state enum (IDLE, PULSE, SETTLE, ACK)
  - the op encoding constants OP_SET=1 and OP_CLR=0
- Sub-module rr_arbiter (parameter NREQ) takes req, pointer and a grant-enable input. It outputs a one-hot grant and the encoded index.
- Top level contains the FSM, counter, op/idx latches, and the q_fb check register.

## Test plan
- Single set, then single clear: req[0]=1 with op=1 → s high in cycles 1-2 with en, ack[0] in cycle 4, err=0, q_fb=1. Then a clear gives r pulse, ack[0], and q_fb=0.
- Simultaneous req=4'b1111 with op=4'b1010 from reset → grants in order 0,1,2,3. Four acks, each 4 cycles apart plus one IDLE cycle. Final Q=1 (requester 3 sets). s&r is never 1 throughout.
- Fairness: req[0] and req[2] held high continuously → grants alternate 0,2,0,2. The pointer advances past each serviced index.
- Fault check: tie q_fb=0 and issue a set from requester 1 → ack[1] and err both pulse in the same cycle.
- Reset mid-PULSE: assert rst in cycle 2 of a set → s=r=en=0 the next cycle, no ack or err, busy=0. The following request is arbitrated from pointer 0.
- Parameter sweep PULSE_CYCLES=1, SETTLE_CYCLES=3 → the en pulse lasts 1 cycle and ack arrives in cycle 5.
